// File: rtl/mdu.sv
// Multiply/divide unit owning HI/LO; mult/div run for a fixed number of cycles, mt*/mf* are zero-latency.
// Results are computed at start and held pending, then committed to HI/LO when the countdown expires.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic [3:0]  mdOp,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        start,
  output logic        busy,
  output logic [31:0] hiLoOut
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] phi_q, phi_d;
  logic [31:0] plo_q, plo_d;
  logic        dz_q, dz_d;

  logic        is_start_op;
  logic        is_div_op;
  logic        commit;

  logic [63:0] prod_s, prod_u;
  logic        div_zero;
  logic [31:0] dvs_u, quo_u, rem_u;
  logic [31:0] mag_a, mag_b, mag_b_safe, quo_m, rem_m, quo_s, rem_s;

  // Sign-extending then taking the low 64 bits of an unsigned product yields the signed product.
  assign prod_s = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
  assign prod_u = {32'd0, srcA} * {32'd0, srcB};

  assign div_zero = (srcB == 32'd0);
  assign dvs_u    = div_zero ? 32'd1 : srcB;
  assign quo_u    = srcA / dvs_u;
  assign rem_u    = srcA % dvs_u;

  // Signed divide on magnitudes avoids the 0x80000000 / -1 overflow case entirely.
  assign mag_a      = srcA[31] ? (32'd0 - srcA) : srcA;
  assign mag_b      = srcB[31] ? (32'd0 - srcB) : srcB;
  assign mag_b_safe = div_zero ? 32'd1 : mag_b;
  assign quo_m      = mag_a / mag_b_safe;
  assign rem_m      = mag_a % mag_b_safe;
  assign quo_s      = (srcA[31] ^ srcB[31]) ? (32'd0 - quo_m) : quo_m;
  assign rem_s      = srcA[31] ? (32'd0 - rem_m) : rem_m;

  assign is_start_op = valid && (mdOp == OP_MULT || mdOp == OP_MULTU ||
                                 mdOp == OP_DIV  || mdOp == OP_DIVU);
  assign is_div_op   = (mdOp == OP_DIV) || (mdOp == OP_DIVU);
  assign busy        = (state_q == S_RUN);
  assign start       = is_start_op && (state_q == S_IDLE);

  always_comb begin
    hiLoOut = 32'd0;
    if (valid && mdOp == OP_MFHI) hiLoOut = hi_q;
    else if (valid && mdOp == OP_MFLO) hiLoOut = lo_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    dz_d    = dz_q;
    commit  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = is_div_op ? DIV_CNT : MULT_CNT;
          dz_d    = is_div_op && div_zero;
          case (mdOp)
            OP_MULT:  {phi_d, plo_d} = prod_s;
            OP_MULTU: {phi_d, plo_d} = prod_u;
            OP_DIV: begin
              phi_d = rem_s;
              plo_d = quo_s;
            end
            default: begin
              phi_d = rem_u;
              plo_d = quo_u;
            end
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          commit  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (valid && mdOp == OP_MTHI) hi_d = srcA;
    if (valid && mdOp == OP_MTLO) lo_d = srcA;

    // A commit overrides a move-to landing on the same edge.
    if (commit && !dz_q) begin
      hi_d = phi_q;
      lo_d = plo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      dz_q    <= dz_d;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: directed vector table, corner-case sequences and randomized ops against an arithmetic model.
module tb_mdu;

  localparam logic [3:0] MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
  localparam logic [3:0] MTHI = 4'd5, MTLO = 4'd6, MFHI = 4'd7, MFLO = 4'd8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [3:0]  mdOp;
  logic [31:0] srcA, srcB;
  logic        start, busy;
  logic [31:0] hiLoOut;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_hi, m_lo;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vt [8];

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .mdOp(mdOp),
    .srcA(srcA), .srcB(srcB), .start(start), .busy(busy), .hiLoOut(hiLoOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    valid = 1'b0;
    mdOp  = 4'd0;
    srcA  = 32'd0;
    srcB  = 32'd0;
  endtask

  task automatic rd(input string nm, input logic [3:0] op, input logic [31:0] exp);
    valid = 1'b1;
    mdOp  = op;
    #1;
    chk(nm, hiLoOut, exp);
    idle_in();
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    valid = 1'b1;
    mdOp  = op;
    srcA  = v;
    cyc();
    idle_in();
  endtask

  // Start an op in the current cycle and check start/busy across the whole run.
  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = (op == DIV || op == DIVU) ? 10 : 5;
    valid = 1'b1; mdOp = op; srcA = a; srcB = b;
    #1;
    chk({nm, " start"}, {31'd0, start}, 32'd1);
    cyc();
    idle_in();
    for (int i = 1; i <= n; i++) begin
      chk({nm, " busy"}, {31'd0, busy}, 32'd1);
      cyc();
    end
    chk({nm, " idle after"}, {31'd0, busy}, 32'd0);
  endtask

  // Reference: plain 64-bit arithmetic on the architectural definition.
  task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint     sp, sq, sr;
    logic [63:0] up;
    case (op)
      MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        m_hi = sp[63:32]; m_lo = sp[31:0];
      end
      MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        m_hi = up[63:32]; m_lo = up[31:0];
      end
      DIV: if (b != 32'd0) begin
        sq = longint'($signed(a)) / longint'($signed(b));
        sr = longint'($signed(a)) % longint'($signed(b));
        m_lo = sq[31:0]; m_hi = sr[31:0];
      end
      DIVU: if (b != 32'd0) begin
        m_lo = a / b; m_hi = a % b;
      end
      MTHI: m_hi = a;
      MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  initial begin
    vt[0] = '{MULT,  32'hFFFFFFFE, 32'd3,          32'hFFFFFFFF, 32'hFFFFFFFA};
    vt[1] = '{MULTU, 32'hFFFFFFFE, 32'd3,          32'h00000002, 32'hFFFFFFFA};
    vt[2] = '{DIV,   32'hFFFFFFF9, 32'd2,          32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[3] = '{DIVU,  32'd7,        32'd2,          32'd1,        32'd3};
    vt[4] = '{DIV,   32'h80000000, 32'hFFFFFFFF,   32'd0,        32'h80000000};
    vt[5] = '{DIV,   32'd7,        32'hFFFFFFFE,   32'd1,        32'hFFFFFFFD};
    vt[6] = '{DIVU,  32'hFFFFFFFF, 32'h10,         32'hF,        32'h0FFFFFFF};
    vt[7] = '{MULT,  32'h7FFFFFFF, 32'h7FFFFFFF,   32'h3FFFFFFF, 32'h00000001};

    rst_n = 1'b0;
    idle_in();
    cyc();
    chk("reset start", {31'd0, start}, 32'd0);
    chk("reset hiLoOut", hiLoOut, 32'd0);
    valid = 1'b1; mdOp = MULT; srcA = 32'd5; srcB = 32'd5;
    #1;
    chk("start comb in reset", {31'd0, start}, 32'd1);
    cyc();
    chk("busy held in reset", {31'd0, busy}, 32'd0);
    idle_in();
    rst_n = 1'b1;
    cyc();
    chk("busy after reset", {31'd0, busy}, 32'd0);
    rd("HI after reset", MFHI, 32'd0);
    rd("LO after reset", MFLO, 32'd0);

    foreach (vt[i]) begin
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b);
      rd($sformatf("vec%0d HI", i), MFHI, vt[i].hi);
      rd($sformatf("vec%0d LO", i), MFLO, vt[i].lo);
    end

    // Move-to is visible to the very next read; divide-by-zero leaves HI/LO alone.
    mt(MTHI, 32'h1234);
    rd("mthi next cycle", MFHI, 32'h1234);
    mt(MTLO, 32'h5678);
    run_op("div0", DIV, 32'd9, 32'd0);
    rd("div0 HI", MFHI, 32'h1234);
    rd("div0 LO", MFLO, 32'h5678);
    run_op("divu0", DIVU, 32'd9, 32'd0);
    rd("divu0 LO", MFLO, 32'h5678);

    // Reset mid-run discards the pending product.
    valid = 1'b1; mdOp = MULT; srcA = 32'd3; srcB = 32'd4;
    cyc();
    idle_in();
    cyc();
    cyc();
    rst_n = 1'b0;
    cyc();
    chk("busy after mid-run reset", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    rd("LO after mid-run reset", MFLO, 32'd0);
    for (int i = 0; i < 6; i++) cyc();
    rd("no late commit", MFLO, 32'd0);

    // Overlap: MTLO during run is overwritten, second MULT ignored.
    valid = 1'b1; mdOp = MULT; srcA = 32'd2; srcB = 32'd3;
    cyc();
    idle_in();
    cyc();
    mt(MTLO, 32'hAAAA);
    valid = 1'b1; mdOp = MULT; srcA = 32'd5; srcB = 32'd7;
    #1;
    chk("start ignored in run", {31'd0, start}, 32'd0);
    cyc();
    idle_in();
    cyc();
    cyc();
    chk("overlap busy done", {31'd0, busy}, 32'd0);
    rd("overlap LO", MFLO, 32'd6);
    rd("overlap HI", MFHI, 32'd0);
    cyc();
    chk("no second op", {31'd0, busy}, 32'd0);

    // MTLO on the commit edge loses to the commit.
    valid = 1'b1; mdOp = MULTU; srcA = 32'd10; srcB = 32'd11;
    cyc();
    idle_in();
    for (int i = 0; i < 4; i++) cyc();
    mt(MTLO, 32'hBBBB);
    rd("commit beats mtlo", MFLO, 32'd110);

    // Bubble slots are ignored.
    valid = 1'b0; mdOp = MULT; srcA = 32'd9; srcB = 32'd9;
    #1;
    chk("invalid start", {31'd0, start}, 32'd0);
    cyc();
    chk("invalid busy", {31'd0, busy}, 32'd0);
    mdOp = MFHI;
    #1;
    chk("invalid mfhi", hiLoOut, 32'd0);
    valid = 1'b1; mdOp = 4'd12;
    #1;
    chk("op 12 start", {31'd0, start}, 32'd0);
    chk("op 12 out", hiLoOut, 32'd0);
    cyc();
    idle_in();
    rd("LO unchanged", MFLO, 32'd110);

    m_hi = 32'd0; m_lo = 32'd110;
    for (int k = 0; k < 40; k++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(1, 6));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) b = b & 32'hFF;
      model_op(op, a, b);
      if (op == MTHI || op == MTLO) mt(op, a);
      else run_op($sformatf("rnd%0d", k), op, a, b);
      rd($sformatf("rnd%0d HI", k), MFHI, m_hi);
      rd($sformatf("rnd%0d LO", k), MFLO, m_lo);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit in the E stage of the pipelined CPU, the consumer of the `mdOp` field produced by the instruction decoder. It owns the HI and LO registers and executes signed and unsigned multiply and divide with fixed multi-cycle latency. It also performs mthi, mtlo, mfhi and mflo. `start` and `busy` feed the hazard unit, which stalls any md-class instruction in D while the unit is occupied.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy duration for mult/multu.
- `DIV_CYCLES`, default 10: busy duration for div/divu.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `valid`  in  1  E-stage instruction is live; 0 for a bubble or flushed slot.
- `mdOp`  in  4  operation code. Encoding: NOT_MD=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8. Values 9–15 are treated as NOT_MD.
- `srcA`  in  32  forwarded GPR[rs].
- `srcB`  in  32  forwarded GPR[rt].
- `start`  out  1  combinational; 1 when `valid` and `mdOp` is in {MULT, MULTU, DIV, DIVU} and `busy`=0.
- `busy`  out  1  registered; 1 while an operation is in flight.
- `hiLoOut`  out  32  combinational. Equals HI when `valid` and `mdOp`=MFHI, LO when `valid` and `mdOp`=MFLO, else 0.

## Operation
- State: IDLE or RUN; 4-bit down-counter `cnt`; pending registers `pHi` and `pLo`; architectural registers HI and LO.
- IDLE with `start`=1: capture the result into `pHi`/`pLo` and set `cnt` to the op's cycle count. Go to RUN, so `busy`=1 from the next cycle.
  - MULT: {pHi,pLo} = $signed(srcA) × $signed(srcB), full 64 bits.
  - MULTU: same, unsigned.
  - DIV: pLo = signed quotient truncated toward zero; pHi = remainder with the sign of the dividend (e.g. −7/2 gives q=−3, r=−1). 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0.
  - DIVU: unsigned quotient and remainder.
  - Divisor 0 (DIV or DIVU): the RUN phase is still taken, but HI and LO are left unchanged on commit.
- RUN: `cnt` decrements each cycle. On the edge where `cnt`=1, the pending result is written to HI/LO (unless divide-by-zero), `cnt` becomes 0, and the unit returns to IDLE.
- MTHI or MTLO with `valid`: HI (or LO) ← `srcA` on the next edge, in either state.
  - If this write lands on the same edge as a RUN commit, the commit wins for that register.
  - A later commit always overwrites values written by mthi/mtlo during RUN.
- MFHI/MFLO read the architectural HI/LO. During RUN they return the pre-operation value. The hazard unit guarantees these reads never occur during RUN; the unit does not stall them itself.
- A start-class `mdOp` during RUN is ignored: `start`=0 and no state change. The hazard unit must not present one.
- `valid`=0: `mdOp` is ignored entirely. `hiLoOut`=0 and `start`=0.

## Timing
- Reset (`rst_n`=0 at an edge) sets HI=0, LO=0, `pHi`=`pLo`=0, `cnt`=0, state IDLE, `busy`=0.
  - During reset, `start` and `hiLoOut` follow their combinational rules; with `valid`=0 both are 0.
  - Reset mid-RUN discards the pending result; HI/LO read 0 afterwards.
- Start in cycle T (mult):
  - `busy`=1 in cycles T+1 … T+5.
  - New HI/LO are visible from T+6; `busy`=0 in T+6.
- Start in cycle T (div): `busy`=1 in T+1 … T+10; result visible from T+11.
- Back-to-back: a new start is accepted in the first cycle with `busy`=0 (T+6 for mult).
- The hazard unit must treat `start`|`busy` as occupied; a start and an md-class instruction in D in the same cycle must stall D.
- Zero-latency ops: mthi/mtlo take effect at the next edge, and a following mfhi reads the new value.

## Test plan
- MULT: srcA=0xFFFFFFFE (−2), srcB=3 in cycle T.
  - Required: `start`=1 in T; `busy`=1 in T+1..T+5; MFHI in T+6 → 0xFFFFFFFF; MFLO → 0xFFFFFFFA.
  - MULTU with the same operands: HI=0x00000002, LO=0xFFFFFFFA.
- DIV: srcA=−7, srcB=2.
  - Required: `busy` for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7/2: LO=3, HI=1.
  - DIV 0x80000000 / −1: LO=0x80000000, HI=0.
- Divide-by-zero: MTHI 0x1234, MTLO 0x5678, then DIV x/0.
  - Required: `busy` for 10 cycles, then HI=0x1234, LO=0x5678.
- Reset mid-RUN: MULT 3×4, then `rst_n`=0 in T+3.
  - Required: `busy`=0 in T+4; MFLO → 0; no late commit of 12.
- Overlap: MULT 2×3 at T; MTLO 0xAAAA at T+2; MFLO at T+6.
  - Required: MFLO → 6.
  - A second MULT presented at T+3 is ignored (`start`=0), and HI/LO reflect only the first op.
- `valid`=0 with `mdOp`=MULT: `start`=0, `busy` stays 0, HI/LO unchanged. With `mdOp`=MFHI: `hiLoOut`=0.
